// File: rtl/data_rec_pkg.sv
// Record layout shared by the CF/NAND packer and unpacker: word count, byte count,
// the collect FSM states and the byte-index split into word index and byte lane.
package data_rec_pkg;

   localparam int NUM_WORDS  = 17;
   localparam int REC_BYTES  = 4 * NUM_WORDS;
   localparam int IDX_W      = 7;
   localparam int WORD_IDX_W = 5;

   localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(REC_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      COMMIT
   } rec_state_t;

   // Byte n of a record lands in word n/4, lane n%4 (lane 0 = bits 7:0).
   function automatic logic [WORD_IDX_W-1:0] word_index(input logic [IDX_W-1:0] idx);
      return idx[IDX_W-1:2];
   endfunction

   function automatic logic [1:0] byte_lane(input logic [IDX_W-1:0] idx);
      return idx[1:0];
   endfunction

endpackage

// File: rtl/data_unpack_if.sv
// Byte-stream handshake from the NAND page-read path into the record unpacker.
interface data_unpack_if;

   logic       start;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_ready;

   modport master (
      output start,
      output rd_valid,
      output rd_data,
      input  rd_ready
   );

   modport slave (
      input  start,
      input  rd_valid,
      input  rd_data,
      output rd_ready
   );

endinterface

// File: rtl/rec_word_shadow.sv
// Shadow register file for a record in progress: byte-lane writes in, all words out
// in parallel so the whole record can be committed on a single edge.
module rec_word_shadow
   import data_rec_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    wr_en,
   input  logic [WORD_IDX_W-1:0]   wr_word,
   input  logic [1:0]              wr_lane,
   input  logic [7:0]              wr_data,
   output logic [NUM_WORDS*32-1:0] rd_all
);

   logic [31:0] words [NUM_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            words[w] <= '0;
         end
      end else if (clear) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            words[w] <= '0;
         end
      end else if (wr_en && (wr_word < WORD_IDX_W'(NUM_WORDS))) begin
         words[wr_word][{wr_lane, 3'b000} +: 8] <= wr_data;
      end
   end

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_rd
      assign rd_all[w*32 +: 32] = words[w];
   end

endmodule

// File: rtl/data_unpack.sv
// Rebuilds the 17-word parameter record from the NAND read byte stream; the output
// words change together, and only once a complete record has been collected.
module data_unpack
   import data_rec_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   data_unpack_if.slave     bus,
   output logic [IDX_W-1:0] byte_idx,
   output logic             rec_done,
   output logic             short_err,
   output logic [31:0]      sct_period,
   output logic [31:0]      sct1_time,
   output logic [31:0]      sct2_time,
   output logic [31:0]      sct3_time,
   output logic [31:0]      sct4_time,
   output logic [31:0]      sct5_time,
   output logic [31:0]      sct6_time,
   output logic [31:0]      sct7_time,
   output logic [31:0]      sct8_time,
   output logic [31:0]      sct9_time,
   output logic [31:0]      sct10_time,
   output logic [31:0]      sct11_time,
   output logic [31:0]      sct12_time,
   output logic [31:0]      sct13_time,
   output logic [31:0]      sct14_time,
   output logic [31:0]      sct15_time,
   output logic [31:0]      sct16_time
);

   rec_state_t              state_q, state_d;
   logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
   logic                    short_err_q, short_err_d;
   logic                    rec_done_q;
   logic                    shadow_clear;
   logic                    shadow_wr;
   logic                    commit;
   logic [NUM_WORDS*32-1:0] shadow_all;
   logic [31:0]             out_words [NUM_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         byte_idx_q  <= '0;
         short_err_q <= 1'b0;
         rec_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         short_err_q <= short_err_d;
         rec_done_q  <= commit;
      end
   end

   // start outranks a byte offered in the same cycle; a restart mid-record is an abort.
   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      short_err_d  = short_err_q;
      shadow_clear = 1'b0;
      shadow_wr    = 1'b0;
      commit       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d      = COLLECT;
               byte_idx_d   = '0;
               shadow_clear = 1'b1;
            end
         end
         COLLECT: begin
            if (bus.start) begin
               if (byte_idx_q != '0) begin
                  short_err_d  = 1'b1;
                  byte_idx_d   = '0;
                  shadow_clear = 1'b1;
               end
            end else if (bus.rd_valid) begin
               shadow_wr = 1'b1;
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = COMMIT;
               end else begin
                  byte_idx_d = byte_idx_q + IDX_W'(1);
               end
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   rec_word_shadow u_shadow (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (shadow_clear),
      .wr_en   (shadow_wr),
      .wr_word (word_index(byte_idx_q)),
      .wr_lane (byte_lane(byte_idx_q)),
      .wr_data (bus.rd_data),
      .rd_all  (shadow_all)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            out_words[w] <= '0;
         end
      end else if (commit) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            out_words[w] <= shadow_all[w*32 +: 32];
         end
      end
   end

   assign bus.rd_ready = (state_q == COLLECT);
   assign byte_idx     = byte_idx_q;
   assign rec_done     = rec_done_q;
   assign short_err    = short_err_q;

   assign sct_period = out_words[0];
   assign sct1_time  = out_words[1];
   assign sct2_time  = out_words[2];
   assign sct3_time  = out_words[3];
   assign sct4_time  = out_words[4];
   assign sct5_time  = out_words[5];
   assign sct6_time  = out_words[6];
   assign sct7_time  = out_words[7];
   assign sct8_time  = out_words[8];
   assign sct9_time  = out_words[9];
   assign sct10_time = out_words[10];
   assign sct11_time = out_words[11];
   assign sct12_time = out_words[12];
   assign sct13_time = out_words[13];
   assign sct14_time = out_words[14];
   assign sct15_time = out_words[15];
   assign sct16_time = out_words[16];

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: records are held as 68-byte arrays and the expected words
// are formed from them arithmetically; inputs change and outputs are sampled on negedge.
module tb_data_unpack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  byte_idx;
   logic        rec_done;
   logic        short_err;
   logic [31:0] dut_words [17];

   logic [7:0]  rec_bytes [68];
   logic [31:0] exp_words [17];

   int vectors     = 0;
   int miscompares = 0;
   int done_count  = 0;
   int cyc         = 0;

   data_unpack_if bus ();

   data_unpack dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .byte_idx   (byte_idx),
      .rec_done   (rec_done),
      .short_err  (short_err),
      .sct_period (dut_words[0]),
      .sct1_time  (dut_words[1]),
      .sct2_time  (dut_words[2]),
      .sct3_time  (dut_words[3]),
      .sct4_time  (dut_words[4]),
      .sct5_time  (dut_words[5]),
      .sct6_time  (dut_words[6]),
      .sct7_time  (dut_words[7]),
      .sct8_time  (dut_words[8]),
      .sct9_time  (dut_words[9]),
      .sct10_time (dut_words[10]),
      .sct11_time (dut_words[11]),
      .sct12_time (dut_words[12]),
      .sct13_time (dut_words[13]),
      .sct14_time (dut_words[14]),
      .sct15_time (dut_words[15]),
      .sct16_time (dut_words[16])
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (rec_done === 1'b1) done_count = done_count + 1;
   end

   function automatic logic [31:0] pack_word(input int k);
      return 32'(rec_bytes[4*k]) + 32'(rec_bytes[4*k+1]) * 32'd256
           + 32'(rec_bytes[4*k+2]) * 32'd65536 + 32'(rec_bytes[4*k+3]) * 32'h0100_0000;
   endfunction

   task automatic model_commit();
      for (int k = 0; k < 17; k++) exp_words[k] = pack_word(k);
   endtask

   task automatic model_clear();
      for (int k = 0; k < 17; k++) exp_words[k] = 32'h0;
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < 68; i++) rec_bytes[i] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 68; i++) rec_bytes[i] = 8'($urandom);
   endtask

   task automatic pulse_start();
      bus.start    = 1'b1;
      bus.rd_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rd_valid = 1'b1;
      bus.rd_data  = b;
      @(negedge clk);
      bus.rd_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      bus.rd_valid = 1'b0;
      @(negedge clk);
   endtask

   // gap_mode 0: continuous, 1: idle before every byte, 2: random idle bursts
   task automatic send_record(input int gap_mode);
      for (int i = 0; i < 68; i++) begin
         if (gap_mode == 1) idle_cycle();
         if (gap_mode == 2 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle_cycle();
         send_byte(rec_bytes[i]);
      end
   endtask

   task automatic test_reset();
      bus.start    = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = 8'h00;
      rst_n        = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.rd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_ready got %b want 0", bus.rd_ready); end
      vectors++;
      if (byte_idx !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_byte_idx got %0d want 0", byte_idx); end
      vectors++;
      if (rec_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rec_done got %b want 0", rec_done); end
      vectors++;
      if (short_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_short_err got %b want 0", short_err); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_word%0d got %h want 0", k, dut_words[k]); end
      end
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_full_record();
      int d0, c0;
      for (int i = 0; i < 68; i++) rec_bytes[i] = 8'(i);
      d0 = done_count;
      pulse_start();
      vectors++;
      if (bus.rd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready_after_start got %b want 1", bus.rd_ready); end
      c0 = cyc;
      send_record(0);
      vectors++;
      if (rec_done !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_early got %b want 0", rec_done); end
      @(negedge clk);
      model_commit();
      vectors++;
      if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL full_rec_done got %b want 1", rec_done); end
      vectors++;
      if (cyc - c0 !== 69) begin miscompares++; $display("[TB] FAIL full_latency got %0d want 69", cyc - c0); end
      vectors++;
      if (dut_words[0] !== 32'h03020100) begin miscompares++; $display("[TB] FAIL full_sct_period got %h want 03020100", dut_words[0]); end
      vectors++;
      if (dut_words[16] !== 32'h43424140) begin miscompares++; $display("[TB] FAIL full_sct16 got %h want 43424140", dut_words[16]); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL full_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      @(negedge clk);
      vectors++;
      if (rec_done !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_width got %b want 0", rec_done); end
      vectors++;
      if (done_count - d0 !== 1) begin miscompares++; $display("[TB] FAIL full_done_count got %0d want 1", done_count - d0); end
   endtask

   task automatic test_gapped();
      int d0;
      d0 = done_count;
      pulse_start();
      for (int i = 0; i < 68; i++) begin
         idle_cycle();
         vectors++;
         if (byte_idx !== 7'(i)) begin miscompares++; $display("[TB] FAIL gap_idx_hold got %0d want %0d", byte_idx, i); end
         send_byte(rec_bytes[i]);
         vectors++;
         if (byte_idx !== 7'((i == 67) ? 67 : i + 1)) begin miscompares++; $display("[TB] FAIL gap_idx_step got %0d want %0d", byte_idx, (i == 67) ? 67 : i + 1); end
      end
      @(negedge clk);
      vectors++;
      if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_rec_done got %b want 1", rec_done); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL gap_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      @(negedge clk);
      vectors++;
      if (done_count - d0 !== 1) begin miscompares++; $display("[TB] FAIL gap_done_count got %0d want 1", done_count - d0); end
   endtask

   task automatic test_abort();
      fill_const(8'hAA);
      pulse_start();
      send_record(0);
      @(negedge clk);
      model_commit();
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(8'h55);
      vectors++;
      if (short_err !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_err_before got %b want 0", short_err); end
      pulse_start();
      vectors++;
      if (short_err !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_short_err got %b want 1", short_err); end
      vectors++;
      if (byte_idx !== 7'd0) begin miscompares++; $display("[TB] FAIL abort_byte_idx got %0d want 0", byte_idx); end
      fill_const(8'h55);
      send_record(0);
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== 32'hAAAAAAAA) begin miscompares++; $display("[TB] FAIL abort_hold_word%0d got %h want aaaaaaaa", k, dut_words[k]); end
      end
      @(negedge clk);
      model_commit();
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL abort_new_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      vectors++;
      if (short_err !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_err_sticky got %b want 1", short_err); end
      @(negedge clk);
   endtask

   task automatic test_start_priority();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      bus.start    = 1'b1;
      bus.rd_valid = 1'b1;
      bus.rd_data  = 8'($urandom);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.rd_valid = 1'b0;
      vectors++;
      if (byte_idx !== 7'd0) begin miscompares++; $display("[TB] FAIL prio_byte_idx got %0d want 0", byte_idx); end
      vectors++;
      if (short_err !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_short_err got %b want 1", short_err); end
      fill_random();
      send_record(2);
      @(negedge clk);
      model_commit();
      vectors++;
      if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_rec_done got %b want 1", rec_done); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL prio_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      fill_random();
      pulse_start();
      for (int i = 0; i < 30; i++) send_byte(rec_bytes[i]);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      vectors++;
      if (bus.rd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_rd_ready got %b want 0", bus.rd_ready); end
      vectors++;
      if (byte_idx !== 7'd0) begin miscompares++; $display("[TB] FAIL areset_byte_idx got %0d want 0", byte_idx); end
      vectors++;
      if (short_err !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_short_err got %b want 0", short_err); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL areset_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random();
      pulse_start();
      send_record(2);
      @(negedge clk);
      model_commit();
      vectors++;
      if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_rec_done got %b want 1", rec_done); end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL areset_new_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      @(negedge clk);
   endtask

   task automatic test_commit_start();
      int d0;
      d0 = done_count;
      fill_random();
      pulse_start();
      send_record(1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      model_commit();
      vectors++;
      if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL cstart_rec_done got %b want 1", rec_done); end
      vectors++;
      if (bus.rd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL cstart_ready got %b want 0", bus.rd_ready); end
      for (int i = 0; i < 3; i++) begin
         send_byte(8'($urandom));
         vectors++;
         if (bus.rd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_ready got %b want 0", bus.rd_ready); end
         vectors++;
         if (byte_idx !== 7'd67) begin miscompares++; $display("[TB] FAIL idle_byte_idx got %0d want 67", byte_idx); end
         vectors++;
         if (rec_done !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_rec_done got %b want 0", rec_done); end
      end
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL cstart_word%0d got %h want %h", k, dut_words[k], exp_words[k]); end
      end
      vectors++;
      if (done_count - d0 !== 1) begin miscompares++; $display("[TB] FAIL cstart_done_count got %0d want 1", done_count - d0); end
   endtask

   // Each new start goes in on the earliest edge after the previous commit.
   task automatic test_back_to_back();
      int d0;
      d0 = done_count;
      for (int r = 0; r < 3; r++) begin
         fill_random();
         pulse_start();
         send_record(2);
         @(negedge clk);
         model_commit();
         vectors++;
         if (rec_done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rec_done rec %0d got %b want 1", r, rec_done); end
         for (int k = 0; k < 17; k++) begin
            vectors++;
            if (dut_words[k] !== exp_words[k]) begin miscompares++; $display("[TB] FAIL b2b_word%0d rec %0d got %h want %h", k, r, dut_words[k], exp_words[k]); end
         end
      end
      @(negedge clk);
      vectors++;
      if (done_count - d0 !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d want 3", done_count - d0); end
   endtask

   initial begin
      test_reset();
      test_full_record();
      test_gapped();
      test_abort();
      test_start_priority();
      test_async_reset();
      test_commit_start();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
